page_out_queue: RTL and testbench
=================================

# page_out_queue

Output-side stream queue for a compiled page: buffers tokens produced by the page FSM and forwards them onto the inter-page stream network under valid/back-pressure flow control. It is the producer-end counterpart of the page input queue. One instance sits on each page output stream. Back-pressure is asserted early, with a reserve of slots, so the page datapath can drain its in-flight tokens after it sees the stall.

## Interface
Parameters:
- DEPTH, 16: number of token slots; power of two, at least 4.
- WIDTH, 9: token width; data in [WIDTH-1:1], end-of-stream flag in bit 0.
- RESERVE, 2: slots still accepted after qin_b asserts; 1 ≤ RESERVE < DEPTH.

Ports:
- clock, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low; clears all state immediately.
- qin_d, input, WIDTH: token from page FSM, {data, eos}.
- qin_v, input, 1: qin_d valid this cycle.
- qin_b, output, 1: back-pressure to page FSM; registered.
- qout_d, output, WIDTH: head token to the stream network.
- qout_v, output, 1: head token valid.
- qout_b, input, 1: downstream back-pressure.
- level, output, $clog2(DEPTH)+1: current occupancy.
- ovf, output, 1: sticky overflow error.

## Operation
- Storage is a DEPTH-entry register array with wr_ptr/rd_ptr ($clog2(DEPTH) bits, natural wrap) and a count register (0..DEPTH).
- Enqueue condition: qin_v && (count < DEPTH || deq). qin_b is advisory. Writes are accepted while qin_b=1 until the array is truly full.
- Dequeue condition: deq = qout_v && !qout_b.
- count_next = count + enq − deq.
- Simultaneous enqueue and dequeue:
  - At full, both complete and count stays at DEPTH.
  - At empty, only the enqueue occurs, because qout_v=0.
- Overflow: qin_v && count==DEPTH && !deq.
  - The token is dropped.
  - ovf sets and holds until reset.
  - Pointers and count are unchanged.
- EOS is carried in bit 0 like any data bit. The queue does not interpret it, and tokens after EOS are queued normally.
- qout_v = (count != 0).
- qout_d = mem[rd_ptr]. It is held stable while qout_v && qout_b.
- qin_b register loads (count_next ≥ DEPTH − RESERVE).
- level = count.
- Reset values:
  - count=0, pointers=0.
  - qin_b=0, qout_v=0, ovf=0.
  - qout_d is don't-care (array not reset).
- Reset asserted mid-operation discards all queued tokens. No qout_v pulse is issued after reset release until a new enqueue.

## Timing
- Latency: a token enqueued into an empty queue at edge N gives qout_v=1 and qout_d valid after edge N, i.e. 1 cycle, with no combinational path from qin to qout.
- qin_b reflects the occupancy produced by edge N from the cycle immediately after edge N, with no combinational path from qout_b to qin_b.
- The producer may issue up to RESERVE further tokens after first sampling qin_b=1 without overflow.
- Throughput: 1 token/cycle sustained when qout_b=0.
- Full-to-not-full: one dequeue from count=DEPTH−RESERVE deasserts qin_b on the next edge. That holds only if no enqueue occurs in the same cycle.

## Structure
- Shared package (page_queue_pkg):
  - default DEPTH/WIDTH/RESERVE constants;
  - token field positions (EOS_BIT=0, DATA_LSB=1);
  - a count-width function.
- These constants are shared with the page input queue.
- One natural sub-module, page_queue_ram: the DEPTH×WIDTH register array with write enable/address and an asynchronous read port. Pointer, count and flow-control logic stay in page_out_queue.

## Test plan
- Reset/idle:
  - Stimulus: reset low mid-stream with 5 tokens queued, then release.
  - Required: qout_v=0, level=0, qin_b=0, ovf=0; no token emerges until a new qin_v.
- Latency/order:
  - Stimulus: write 0x0A2, 0x0B4, 0x0C7 (EOS) on consecutive cycles with qout_b=0.
  - Required: qout_d shows the same three tokens in order, one cycle after each write; level peaks at 1.
- Early back-pressure:
  - Stimulus: DEPTH=16, RESERVE=2, qout_b=1, write continuously.
  - Required: qin_b rises in the cycle after the 14th accepted token.
  - Required: the 15th and 16th tokens are accepted; level=16.
  - Required: the 17th is dropped, ovf=1 thereafter.
- Full simultaneous:
  - Stimulus: at level=16, drop qout_b and assert qin_v for 4 cycles.
  - Required: level stays 16, 4 tokens leave in FIFO order, 4 new tokens are accepted, ovf unchanged.
- Stall stability:
  - Stimulus: qout_b toggles with a random pattern during a 100-token burst with pointer wrap.
  - Required: qout_d is constant while stalled; the output sequence equals the input sequence exactly.
- Drain:
  - Stimulus: from level=14 with qin_b=1, dequeue one token with no write.
  - Required: qin_b=0 after the next edge; level=13.

Source files
------------

// File: rtl/page_queue_pkg.sv
`default_nettype none
// ============================================================================
// page_queue_pkg : constants and helpers shared by the page input/output queues
// Revision: 1.0
// ============================================================================
package page_queue_pkg;

  localparam int PQ_DEPTH   = 16;
  localparam int PQ_WIDTH   = 9;
  localparam int PQ_RESERVE = 2;

  // Token layout: {data[WIDTH-1:1], eos}
  localparam int EOS_BIT  = 0;
  localparam int DATA_LSB = 1;

  // Occupancy needs one extra bit so that DEPTH itself is representable
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/page_queue_ram.sv
`default_nettype none
// ============================================================================
// page_queue_ram : DEPTH x WIDTH token store, synchronous write, async read
// Revision: 1.0
// ============================================================================
module page_queue_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Contents are deliberately not reset; occupancy tracking masks stale slots
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/page_out_queue.sv
`default_nettype none
// ============================================================================
// page_out_queue : page output stream queue with early (reserved) back-pressure
// Revision: 1.0
// ============================================================================
module page_out_queue
  import page_queue_pkg::*;
#(
  parameter int DEPTH   = PQ_DEPTH,
  parameter int WIDTH   = PQ_WIDTH,
  parameter int RESERVE = PQ_RESERVE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            qin_d,
  input  logic                        qin_v,
  output logic                        qin_b,
  output logic [WIDTH-1:0]            qout_d,
  output logic                        qout_v,
  input  logic                        qout_b,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] C_THRESH = CW'(DEPTH - RESERVE);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_qin_b;
  logic          r_ovf;

  logic          w_full;
  logic          w_deq;
  logic          w_enq;
  logic          w_ovf_evt;
  logic [CW-1:0] w_count_next;

  assign w_full    = (r_count == C_FULL);
  assign qout_v    = (r_count != '0);
  assign w_deq     = qout_v && !qout_b;
  // A write into a full array still succeeds when the head leaves this cycle
  assign w_enq     = qin_v && (!w_full || w_deq);
  assign w_ovf_evt = qin_v && w_full && !w_deq;

  assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_qin_b  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      // Asserted early so RESERVE in-flight tokens still fit after the stall
      r_qin_b <= (w_count_next >= C_THRESH);
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
    end
  end

  page_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clock),
    .i_we    (w_enq),
    .i_waddr (r_wr_ptr),
    .i_wdata (qin_d),
    .i_raddr (r_rd_ptr),
    .o_rdata (qout_d)
  );

  assign qin_b = r_qin_b;
  assign level = r_count;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_page_out_queue.sv
`default_nettype none
// ============================================================================
// tb_page_out_queue : directed vector table plus reset and random-stall runs
// Revision: 1.0
// ============================================================================
module tb_page_out_queue;

  localparam int DEPTH = 16;
  localparam int WIDTH = 9;
  localparam int RESERVE = 2;
  localparam int LW = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] qin_d = '0;
  logic             qin_v = 1'b0;
  logic             qin_b;
  logic [WIDTH-1:0] qout_d;
  logic             qout_v;
  logic             qout_b = 1'b0;
  logic [LW-1:0]    level;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  page_out_queue #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .RESERVE (RESERVE)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .qin_d  (qin_d),
    .qin_v  (qin_v),
    .qin_b  (qin_b),
    .qout_d (qout_d),
    .qout_v (qout_v),
    .qout_b (qout_b),
    .level  (level),
    .ovf    (ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             b;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic [LW-1:0]    el;
    logic             eb;
    logic             eo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input int d, input logic b, input logic ev,
                     input int ed, input int el, input logic eb, input logic eo);
    vec_t t;
    t.v = v; t.d = WIDTH'(d); t.b = b; t.ev = ev; t.ed = WIDTH'(ed);
    t.el = LW'(el); t.eb = eb; t.eo = eo;
    vecs.push_back(t);
  endtask

  function automatic logic [WIDTH-1:0] tok(input int i);
    return {8'(i * 3 + 1), 1'(i % 5 == 4)};
  endfunction

  initial begin
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] held;
    logic             stalled;
    int               sent;
    int               rcvd;
    int               stall_seen;

    // ---------------- vector table ----------------
    add(1, 'h0A2, 0, 1, 'h0A2, 1, 0, 0);
    add(1, 'h0B4, 0, 1, 'h0B4, 1, 0, 0);
    add(1, 'h0C7, 0, 1, 'h0C7, 1, 0, 0);
    add(0, 'h000, 0, 0, 'h000, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      add(1, 'h010 + k, 1, 1, 'h011, k, (k >= 14), 0);
    end
    add(1, 'h021, 1, 1, 'h011, 16, 1, 1);
    for (int j = 0; j < 4; j++) begin
      add(1, 'h100 + j, 0, 1, 'h012 + j, 16, 1, 1);
    end
    add(0, 'h000, 0, 1, 'h016, 15, 1, 1);
    add(0, 'h000, 0, 1, 'h017, 14, 1, 1);
    add(0, 'h000, 0, 1, 'h018, 13, 0, 1);
    add(0, 'h000, 1, 1, 'h018, 13, 0, 1);

    // ---------------- reset / idle ----------------
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_qout_v", 32'(qout_v), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_qin_b", 32'(qin_b), 0);
    chk("rst_ovf", 32'(ovf), 0);

    qout_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      qin_v = 1'b1;
      qin_d = WIDTH'(9'h050 + 9'(i));
    end
    @(negedge clock);
    qin_v = 1'b0;
    #1;
    chk("pre_rst_level", 32'(level), 5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_qout_v", 32'(qout_v), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_qin_b", 32'(qin_b), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    @(negedge clock);
    reset = 1'b1;
    qout_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk("post_rst_idle_v", 32'(qout_v), 0);
    end
    @(negedge clock);
    qin_v = 1'b1;
    qin_d = 9'h1AB;
    @(posedge clock);
    #1;
    chk("post_rst_first_v", 32'(qout_v), 1);
    chk("post_rst_first_d", 32'(qout_d), 32'h1AB);
    @(negedge clock);
    qin_v = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_drained", 32'(qout_v), 0);

    // ---------------- table run ----------------
    foreach (vecs[i]) begin
      @(negedge clock);
      qin_v  = vecs[i].v;
      qin_d  = vecs[i].d;
      qout_b = vecs[i].b;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_qout_v", i), 32'(qout_v), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d_qout_d", i), 32'(qout_d), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].el));
      chk($sformatf("vec%0d_qin_b", i), 32'(qin_b), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].eo));
    end

    // ---------------- drain leftovers ----------------
    @(negedge clock);
    qin_v  = 1'b0;
    qout_b = 1'b0;
    for (int c = 0; c < 40 && level != 0; c++) @(negedge clock);
    chk("drain_level", 32'(level), 0);

    // ---------------- random stall burst ----------------
    sent = 0;
    rcvd = 0;
    stalled = 1'b0;
    stall_seen = 0;
    held = '0;
    for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
      @(negedge clock);
      qout_b = ($urandom_range(0, 2) == 0);
      qin_v  = (sent < 100) && !qin_b && ($urandom_range(0, 3) != 0);
      qin_d  = tok(sent);
      #1;
      if (stalled) begin
        chk("stall_hold", 32'(qout_d), 32'(held));
        stall_seen++;
      end
      if (qout_v && !qout_b) begin
        if (exp_q.size() == 0) begin
          chk("burst_unexpected_token", 32'(qout_d), 32'hFFFF_FFFF);
        end else begin
          chk("burst_order", 32'(qout_d), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        rcvd++;
      end
      stalled = qout_v && qout_b;
      held    = qout_d;
      if (qin_v && (level < LW'(DEPTH) || (qout_v && !qout_b))) begin
        exp_q.push_back(qin_d);
        sent++;
      end
    end
    chk("burst_received", 32'(rcvd), 100);
    chk("burst_ovf_sticky", 32'(ovf), 1);
    @(negedge clock);
    qin_v = 1'b0;
    @(posedge clock);
    #1;
    chk("burst_final_level", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
